// File: rtl/rsa_seq_ctrl.sv
// Job sequencer for one RSA systolic array: streams X/Y operands from memory,
// starts the array, waits its latency, then drains results into a result memory.
module rsa_seq_ctrl #(
  parameter int X      = 3,
  parameter int N      = 3,
  parameter int Y      = 3,
  parameter int IN_LEN = 4,
  parameter int OUT_LEN = 8,
  parameter int MEM_AW = 8,
  parameter int SA_LAT = 13
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [MEM_AW-1:0]  cmd_xbase,
  input  logic [MEM_AW-1:0]  cmd_ybase,
  input  logic [MEM_AW-1:0]  cmd_obase,
  output logic               xmem_rd_en,
  output logic [MEM_AW-1:0]  xmem_addr,
  input  logic [IN_LEN-1:0]  xmem_rd_data,
  output logic               ymem_rd_en,
  output logic [MEM_AW-1:0]  ymem_addr,
  input  logic [IN_LEN-1:0]  ymem_rd_data,
  output logic               Xin_val,
  output logic [IN_LEN-1:0]  Xin_data,
  output logic               Yin_val,
  output logic [IN_LEN-1:0]  Yin_data,
  output logic               SA_start,
  output logic               out_rdy,
  input  logic [OUT_LEN-1:0] out_data,
  output logic               omem_wr_en,
  output logic [MEM_AW-1:0]  omem_addr,
  output logic [OUT_LEN-1:0] omem_wr_data,
  output logic               busy,
  output logic               done
);
  localparam int XN   = X * N;
  localparam int YN   = Y * N;
  localparam int XY   = X * Y;
  localparam int L    = (XN > YN) ? XN : YN;
  // DRAIN counts one past XY to cover the trailing write cycle
  localparam int M1   = (L > XY + 1) ? L : XY + 1;
  localparam int CMAX = (M1 > SA_LAT) ? M1 : SA_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] XN_C  = CW'(XN);
  localparam logic [CW-1:0] YN_C  = CW'(YN);
  localparam logic [CW-1:0] XY_C  = CW'(XY);
  localparam logic [CW-1:0] L_C   = CW'(L);
  localparam logic [CW-1:0] LAT_C = CW'(SA_LAT);
  localparam logic [CW-1:0] GAP_C = CW'(2);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, START, WAIT, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [MEM_AW-1:0] xbase, ybase, obase;

  assign cnt_nx       = cnt + 1'b1;
  assign Xin_data     = xmem_rd_data;
  assign Yin_data     = ymem_rd_data;
  assign omem_wr_data = out_data;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      xbase      <= '0;
      ybase      <= '0;
      obase      <= '0;
      cmd_rdy    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      xmem_rd_en <= 1'b0;
      xmem_addr  <= '0;
      ymem_rd_en <= 1'b0;
      ymem_addr  <= '0;
      Xin_val    <= 1'b0;
      Yin_val    <= 1'b0;
      SA_start   <= 1'b0;
      out_rdy    <= 1'b0;
      omem_wr_en <= 1'b0;
      omem_addr  <= '0;
    end else begin
      // memory read and RSA drain each have one cycle of latency
      Xin_val    <= xmem_rd_en;
      Yin_val    <= ymem_rd_en;
      omem_wr_en <= out_rdy;
      case (state)
        IDLE: if (cmd_val) begin
          xbase      <= cmd_xbase;
          ybase      <= cmd_ybase;
          obase      <= cmd_obase;
          cnt        <= '0;
          state      <= LOAD;
          cmd_rdy    <= 1'b0;
          busy       <= 1'b1;
          xmem_rd_en <= 1'b1;
          xmem_addr  <= cmd_xbase;
          ymem_rd_en <= 1'b1;
          ymem_addr  <= cmd_ybase;
        end
        LOAD: begin
          xmem_rd_en <= (cnt_nx < XN_C);
          ymem_rd_en <= (cnt_nx < YN_C);
          if (cnt_nx < XN_C) xmem_addr <= xbase + MEM_AW'(cnt_nx);
          if (cnt_nx < YN_C) ymem_addr <= ybase + MEM_AW'(cnt_nx);
          if (cnt_nx == L_C) begin
            state <= GAP;
            cnt   <= '0;
          end else cnt <= cnt_nx;
        end
        GAP: if (cnt == GAP_C) begin
          state    <= START;
          SA_start <= 1'b1;
          cnt      <= '0;
        end else cnt <= cnt_nx;
        START: begin
          SA_start <= 1'b0;
          state    <= WAIT;
          cnt      <= '0;
        end
        WAIT: if (cnt_nx == LAT_C) begin
          state   <= DRAIN;
          out_rdy <= 1'b1;
          cnt     <= '0;
        end else cnt <= cnt_nx;
        DRAIN: begin
          if (out_rdy) omem_addr <= obase + MEM_AW'(cnt);
          out_rdy <= (cnt_nx < XY_C);
          if (cnt == XY_C) begin
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else cnt <= cnt_nx;
        end
        DONE: begin
          done    <= 1'b0;
          state   <= IDLE;
          cmd_rdy <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Directed bench for rsa_seq_ctrl: default 3x3x3 instance plus a 2x3x4 instance,
// with behavioural operand memories and a stand-in RSA result source.
module tb_rsa_seq_ctrl;
  localparam int LL  = 9;
  localparam int SL  = 13;
  localparam int NXY = 9;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       cmd_val, cmd_rdy;
  logic [7:0] cmd_xbase, cmd_ybase, cmd_obase;
  logic       xmem_rd_en, ymem_rd_en;
  logic [7:0] xmem_addr, ymem_addr;
  logic [3:0] xrd, yrd;
  logic       Xin_val, Yin_val;
  logic [3:0] Xin_data, Yin_data;
  logic       SA_start, out_rdy, omem_wr_en, busy, done;
  logic [7:0] out_data, omem_addr, omem_wr_data;

  logic       cmd_val2, cmd_rdy2;
  logic       xmem_rd_en2, ymem_rd_en2;
  logic [7:0] xmem_addr2, ymem_addr2;
  logic [3:0] xrd2, yrd2;
  logic       Xin_val2, Yin_val2;
  logic [3:0] Xin_data2, Yin_data2;
  logic       SA_start2, out_rdy2, omem_wr_en2, busy2, done2;
  logic [7:0] out_data2, omem_addr2, omem_wr_data2;

  logic [3:0] xm [256];
  logic [3:0] ym [256];
  int         cur_xb, cur_yb, ridx;
  int         nchk = 0, nerr = 0;
  time        t_done;

  always #5 clk = ~clk;

  rsa_seq_ctrl u_dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .cmd_xbase(cmd_xbase), .cmd_ybase(cmd_ybase), .cmd_obase(cmd_obase),
    .xmem_rd_en(xmem_rd_en), .xmem_addr(xmem_addr), .xmem_rd_data(xrd),
    .ymem_rd_en(ymem_rd_en), .ymem_addr(ymem_addr), .ymem_rd_data(yrd),
    .Xin_val(Xin_val), .Xin_data(Xin_data), .Yin_val(Yin_val), .Yin_data(Yin_data),
    .SA_start(SA_start), .out_rdy(out_rdy), .out_data(out_data),
    .omem_wr_en(omem_wr_en), .omem_addr(omem_addr), .omem_wr_data(omem_wr_data),
    .busy(busy), .done(done));

  rsa_seq_ctrl #(.X(2), .N(3), .Y(4), .SA_LAT(14)) u_dut2 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_val(cmd_val2), .cmd_rdy(cmd_rdy2),
    .cmd_xbase(cmd_xbase), .cmd_ybase(cmd_ybase), .cmd_obase(cmd_obase),
    .xmem_rd_en(xmem_rd_en2), .xmem_addr(xmem_addr2), .xmem_rd_data(xrd2),
    .ymem_rd_en(ymem_rd_en2), .ymem_addr(ymem_addr2), .ymem_rd_data(yrd2),
    .Xin_val(Xin_val2), .Xin_data(Xin_data2), .Yin_val(Yin_val2), .Yin_data(Yin_data2),
    .SA_start(SA_start2), .out_rdy(out_rdy2), .out_data(out_data2),
    .omem_wr_en(omem_wr_en2), .omem_addr(omem_addr2), .omem_wr_data(omem_wr_data2),
    .busy(busy2), .done(done2));

  // Golden RSA result m (row-major C = X * Y^T) for the given operand bases
  function automatic logic [7:0] gold(input int xb, input int yb, input int m);
    int s = 0;
    for (int k = 0; k < 3; k++)
      s += int'(xm[(xb + (m / 3) * 3 + k) & 255]) * int'(ym[(yb + (m % 3) * 3 + k) & 255]);
    return 8'(s);
  endfunction

  always @(posedge clk) begin
    if (xmem_rd_en)  xrd  <= xm[xmem_addr];
    if (ymem_rd_en)  yrd  <= ym[ymem_addr];
    if (xmem_rd_en2) xrd2 <= xm[xmem_addr2];
    if (ymem_rd_en2) yrd2 <= ym[ymem_addr2];
    out_data <= out_rdy ? gold(cur_xb, cur_yb, ridx) : 8'h00;
    ridx     <= out_rdy ? ridx + 1 : 0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a job at the current negedge (accepted at the next edge = cycle 0) and
  // monitors until the cycle after done; rel is the cycle index seen at each negedge.
  task automatic run_job(input int xb, input int yb, input int ob,
                         input bit hold, input int rst_at, input int lim);
    int xk = 0, yk = 0, xi = 0, yi = 0, wm = 0, sac = 0, roc = 0, dc = 0, ovl = 0;
    int xf = -1, xl = -1, xvf = -1, xvl = -1, yvl = -1, sa_cyc = -1;
    int rof = -1, rol = -1, wf = -1, dcyc = -1;
    chk("cmd_rdy_pre", cmd_rdy, 1);
    cmd_xbase = 8'(xb); cmd_ybase = 8'(yb); cmd_obase = 8'(ob);
    cur_xb = xb; cur_yb = yb;
    cmd_val = 1'b1;
    for (int rel = 1; rel <= lim; rel++) begin
      @(negedge clk);
      if (rel == 1 && !hold) cmd_val = 1'b0;
      if (rel == rst_at) begin
        sys_rst_n = 1'b0;
        #1;
        chk("rst_out_rdy", out_rdy, 0);
        chk("rst_wr_en", omem_wr_en, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_busy", busy, 0);
      end
      if (rst_at > 0 && rel == rst_at + 1) sys_rst_n = 1'b1;
      if (dc > 0 && rel == dcyc + 1) begin
        chk("cmd_rdy_post", cmd_rdy, 1);
        break;
      end
      if (xmem_rd_en) begin
        chk("xaddr", xmem_addr, (xb + xk) & 255);
        if (xk == 0) xf = rel;
        xk++; xl = rel;
      end
      if (ymem_rd_en) begin
        chk("yaddr", ymem_addr, (yb + yk) & 255);
        yk++;
      end
      if (Xin_val) begin
        chk("xin_data", Xin_data, xm[(xb + xi) & 255]);
        if (xi == 0) xvf = rel;
        xi++; xvl = rel;
      end
      if (Yin_val) begin
        chk("yin_data", Yin_data, ym[(yb + yi) & 255]);
        yi++; yvl = rel;
      end
      if (SA_start) begin sac++; sa_cyc = rel; end
      if (out_rdy) begin
        if (roc == 0) rof = rel;
        roc++; rol = rel;
        if (Xin_val || Yin_val) ovl++;
      end
      if (omem_wr_en) begin
        chk("waddr", omem_addr, (ob + wm) & 255);
        chk("wdata", omem_wr_data, gold(xb, yb, wm));
        if (wm == 0) wf = rel;
        wm++;
      end
      if (done) begin dc++; dcyc = rel; t_done = $time; end
    end
    if (rst_at > 0) begin
      chk("no_done_after_rst", dc, 0);
      chk("idle_after_rst", busy, 0);
    end else begin
      chk("xrd_cnt", xk, 9);         chk("xrd_first", xf, 1);     chk("xrd_last", xl, 9);
      chk("yrd_cnt", yk, 9);
      chk("xin_cnt", xi, 9);         chk("xin_first", xvf, 2);    chk("xin_last", xvl, 10);
      chk("yin_cnt", yi, 9);         chk("yin_last", yvl, 10);
      chk("sa_cnt", sac, 1);         chk("sa_cyc", sa_cyc, LL + 4);
      chk("ordy_first", rof, LL + 5 + SL);
      chk("ordy_last", rol, LL + 4 + SL + NXY);
      chk("ordy_cnt", roc, NXY);
      chk("wr_cnt", wm, NXY);        chk("wr_first", wf, LL + 6 + SL);
      chk("done_cnt", dc, 1);        chk("done_cyc", dcyc, LL + 6 + SL + NXY);
      chk("overlap", ovl, 0);
    end
  endtask

  initial begin
    time t_a;
    int x2c, x2f, x2l, y2c, y2f, y2l, sa2, w2, d2;
    for (int a = 0; a < 256; a++) begin
      xm[a] = 4'((a * 7 + 3) & 15);
      ym[a] = 4'((a * 5 + 1) & 15);
    end
    sys_rst_n = 1'b0; cmd_val = 1'b0; cmd_val2 = 1'b0;
    cmd_xbase = 8'h00; cmd_ybase = 8'h00; cmd_obase = 8'h00;
    out_data2 = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1);      chk("rst_busy", busy, 0);
    chk("rst_xrd_en", xmem_rd_en, 0);    chk("rst_xaddr", xmem_addr, 0);
    chk("rst_yaddr", ymem_addr, 0);      chk("rst_sa", SA_start, 0);
    chk("rst_ordy", out_rdy, 0);         chk("rst_oaddr", omem_addr, 0);
    chk("rst_wr_en", omem_wr_en, 0);     chk("rst_done", done, 0);
    chk("rst_xin_val", Xin_val, 0);      chk("rst_cmd_rdy2", cmd_rdy2, 1);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // cmd_val held through a whole default job, then a back-to-back job with new bases
    run_job(8'h00, 8'h20, 8'h40, 1'b1, 0, 60);
    t_a = t_done;
    run_job(8'h10, 8'h50, 8'h90, 1'b0, 0, 60);
    chk("done_gap", int'((t_done - t_a) / 10), 38);

    // address wrap on X operands and results
    run_job(8'hFC, 8'h20, 8'hFA, 1'b0, 0, 60);

    // reset in DRAIN abandons the job, then a fresh job runs normally
    run_job(8'h00, 8'h20, 8'h40, 1'b0, 30, 45);
    run_job(8'h30, 8'h60, 8'h80, 1'b0, 0, 60);

    // unequal sizes: X=2, Y=4, N=3 -> L=12, SA_LAT=14
    x2c = 0; x2f = -1; x2l = -1; y2c = 0; y2f = -1; y2l = -1; sa2 = -1; w2 = 0; d2 = -1;
    cmd_xbase = 8'h00; cmd_ybase = 8'h20; cmd_obase = 8'h40;
    cmd_val2 = 1'b1;
    for (int rel = 1; rel <= 50; rel++) begin
      @(negedge clk);
      if (rel == 1) cmd_val2 = 1'b0;
      if (Xin_val2) begin if (x2c == 0) x2f = rel; x2c++; x2l = rel; end
      if (Yin_val2) begin if (y2c == 0) y2f = rel; y2c++; y2l = rel; end
      if (SA_start2) sa2 = rel;
      if (omem_wr_en2) w2++;
      if (done2) begin d2 = rel; break; end
    end
    chk("u2_xin_cnt", x2c, 6);   chk("u2_xin_first", x2f, 2);  chk("u2_xin_last", x2l, 7);
    chk("u2_yin_cnt", y2c, 12);  chk("u2_yin_first", y2f, 2);  chk("u2_yin_last", y2l, 13);
    chk("u2_sa_cyc", sa2, 16);   chk("u2_wr_cnt", w2, 8);      chk("u2_done_cyc", d2, 40);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
